// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: FSM states, the latched
// instruction record and the scoreboard hazard rule.
package operand_fetch_pkg;

  localparam int ADDR_BITS = 3;
  localparam int DATA_BITS = 8;
  localparam int OP_BITS   = 4;
  localparam int NUM_REGS  = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ISSUE = 2'd2
  } of_state_t;

  typedef struct packed {
    logic [OP_BITS-1:0]   op;
    logic [ADDR_BITS-1:0] rd;
    logic [ADDR_BITS-1:0] rs0;
    logic [ADDR_BITS-1:0] rs1;
    logic                 use_imm;
    logic [DATA_BITS-1:0] imm;
    logic                 wr_rd;
  } instr_t;

  // An instruction may not leave READ while any register it touches is pending.
  // rs1 is ignored when the immediate replaces it; rd only matters if written.
  function automatic logic instr_hazard(input instr_t instr,
                                        input logic   busy_rs0,
                                        input logic   busy_rs1,
                                        input logic   busy_rd);
    return busy_rs0 | (~instr.use_imm & busy_rs1) | (instr.wr_rd & busy_rd);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Register file port bundle. Read ports drive addr/enable and take data back;
// the write port drives all three toward the register file.
interface register_bus #(
  parameter int ADDR_BITS = 3,
  parameter int DATA_BITS = 8
);
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] data;
  logic                 enable;

  modport rd_master (output addr, output enable, input  data);
  modport rd_slave  (input  addr, input  enable, output data);
  modport wr_master (output addr, output enable, output data);
  modport wr_slave  (input  addr, input  enable, input  data);
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits. A register becomes busy when an instruction that
// writes it issues and is released by writeback. When both hit the same
// register on one edge the set wins, because the newer writer is still pending.
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_BITS = operand_fetch_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [ADDR_BITS-1:0] set_addr,
  input  logic                 clr_en,
  input  logic [ADDR_BITS-1:0] clr_addr,
  input  logic [ADDR_BITS-1:0] lk0_addr,
  input  logic [ADDR_BITS-1:0] lk1_addr,
  input  logic [ADDR_BITS-1:0] lk2_addr,
  output logic                 lk0_busy,
  output logic                 lk1_busy,
  output logic                 lk2_busy
);

  localparam int NREGS = 1 << ADDR_BITS;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: apply the writeback clear first, then the issue set on top.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Busy vector storage; reset empties the scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign lk0_busy = busy_q[lk0_addr];
  assign lk1_busy = busy_q[lk1_addr];
  assign lk2_busy = busy_q[lk2_addr];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage in front of the register file. Latches one decoded instruction,
// reads its operands once the scoreboard shows no pending writer, and holds
// {op, rd, a, b} for the ALU until it is accepted. Writeback is forwarded to
// the register file write port unconditionally.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_BITS = operand_fetch_pkg::ADDR_BITS,
  parameter int DATA_BITS = operand_fetch_pkg::DATA_BITS,
  parameter int OP_BITS   = operand_fetch_pkg::OP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_BITS-1:0]   in_op,
  input  logic [ADDR_BITS-1:0] in_rd,
  input  logic [ADDR_BITS-1:0] in_rs0,
  input  logic [ADDR_BITS-1:0] in_rs1,
  input  logic                 in_use_imm,
  input  logic [DATA_BITS-1:0] in_imm,
  input  logic                 in_wr_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_BITS-1:0]   out_op,
  output logic [ADDR_BITS-1:0] out_rd,
  output logic [DATA_BITS-1:0] out_a,
  output logic [DATA_BITS-1:0] out_b,
  input  logic                 wb_valid,
  input  logic [ADDR_BITS-1:0] wb_addr,
  input  logic [DATA_BITS-1:0] wb_data,
  register_bus.rd_master       rd0_bus,
  register_bus.rd_master       rd1_bus,
  register_bus.wr_master       wr_bus
);

  of_state_t            state_q,     state_d;
  instr_t               instr_q,     instr_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OP_BITS-1:0]   out_op_q,    out_op_d;
  logic [ADDR_BITS-1:0] out_rd_q,    out_rd_d;
  logic [DATA_BITS-1:0] out_a_q,     out_a_d;
  logic [DATA_BITS-1:0] out_b_q,     out_b_d;
  logic                 rd0_en_q,    rd0_en_d;
  logic                 rd1_en_q,    rd1_en_d;

  logic busy_rs0_s;
  logic busy_rs1_s;
  logic busy_rd_s;
  logic hazard_s;
  logic issue_s;
  logic sb_set_en_s;

  operand_fetch_scoreboard #(
    .ADDR_BITS (ADDR_BITS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (sb_set_en_s),
    .set_addr (instr_q.rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .lk0_addr (instr_q.rs0),
    .lk1_addr (instr_q.rs1),
    .lk2_addr (instr_q.rd),
    .lk0_busy (busy_rs0_s),
    .lk1_busy (busy_rs1_s),
    .lk2_busy (busy_rd_s)
  );

  // Busy bits are sampled as registered, so a writeback landing this cycle
  // only unblocks the instruction on the following cycle.
  always_comb begin
    hazard_s    = instr_hazard(instr_q, busy_rs0_s, busy_rs1_s, busy_rd_s);
    issue_s     = (state_q == READ) & ~hazard_s;
    sb_set_en_s = issue_s & instr_q.wr_rd;
  end

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    rd0_en_d    = rd0_en_q;
    rd1_en_d    = rd1_en_q;
    case (state_q)
      IDLE: begin
        if (in_valid & in_ready_q) begin
          instr_d = '{op:      in_op,
                      rd:      in_rd,
                      rs0:     in_rs0,
                      rs1:     in_rs1,
                      use_imm: in_use_imm,
                      imm:     in_imm,
                      wr_rd:   in_wr_rd};
          state_d    = READ;
          in_ready_d = 1'b0;
          rd0_en_d   = 1'b1;
          rd1_en_d   = ~in_use_imm;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (issue_s) begin
          state_d     = ISSUE;
          out_valid_d = 1'b1;
          out_op_d    = instr_q.op;
          out_rd_d    = instr_q.rd;
          out_a_d     = rd0_bus.data;
          out_b_d     = instr_q.use_imm ? instr_q.imm : rd1_bus.data;
          rd0_en_d    = 1'b0;
          rd1_en_d    = 1'b0;
        end else begin
          state_d = READ;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        rd0_en_d    = 1'b0;
        rd1_en_d    = 1'b0;
      end
    endcase
  end

  // FSM state and output registers; reset drops any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_op_q    <= {OP_BITS{1'b0}};
      out_rd_q    <= {ADDR_BITS{1'b0}};
      out_a_q     <= {DATA_BITS{1'b0}};
      out_b_q     <= {DATA_BITS{1'b0}};
      rd0_en_q    <= 1'b0;
      rd1_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      rd0_en_q    <= rd0_en_d;
      rd1_en_q    <= rd1_en_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_rd    = out_rd_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;

  assign rd0_bus.addr   = instr_q.rs0;
  assign rd0_bus.enable = rd0_en_q;
  assign rd1_bus.addr   = instr_q.rs1;
  assign rd1_bus.enable = rd1_en_q;

  // Writeback is never held back by the issue FSM.
  assign wr_bus.addr   = wb_addr;
  assign wr_bus.data   = wb_data;
  assign wr_bus.enable = wb_valid;

endmodule
